iterative_shift_unit: RTL and testbench

//  Multi-cycle logical-left / arithmetic-right shifter for the ALU datapath.

---
 rtl/iterative_shift_unit.sv | 106 ++++++++++
 tb/tb_iterative_shift_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/iterative_shift_unit.sv
// ============================================================================
//  Module   : iterative_shift_unit
//  Brief    : Multi-cycle SLL / SRA shifter, one power-of-two stage per clock.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module iterative_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic               ctrl_dir,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               data_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] c_K_FIRST = SHAMT_W'(SHAMT_W - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_amt;
    logic [SHAMT_W-1:0] r_k;
    logic               r_dir;

    logic [WIDTH-1:0]   w_cand [SHAMT_W];
    logic [WIDTH-1:0]   w_stage;

    // Each stage is a fixed-distance shift; the sign bit of r_work never
    // changes under SRA, so it still holds the captured operand MSB.
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int c_SH = 1 << i;
        logic [WIDTH-1:0] w_sll;
        logic [WIDTH-1:0] w_sra;
        assign w_sll     = {r_work[WIDTH-1-c_SH:0], {c_SH{1'b0}}};
        assign w_sra     = {{c_SH{r_work[WIDTH-1]}}, r_work[WIDTH-1:c_SH]};
        assign w_cand[i] = r_dir ? w_sra : w_sll;
    end

    always_comb begin
        w_stage = r_work;
        for (int i = 0; i < SHAMT_W; i++) begin
            if ((r_k == SHAMT_W'(i)) && r_amt[i]) begin
                w_stage = w_cand[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_work         <= '0;
            r_amt          <= '0;
            r_k            <= '0;
            r_dir          <= 1'b0;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
            data_busy      <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (ctrl_start) begin
                        r_work    <= data_operand;
                        r_amt     <= ctrl_shiftamt;
                        r_dir     <= ctrl_dir;
                        r_k       <= c_K_FIRST;
                        data_busy <= 1'b1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_work <= w_stage;
                    if (r_k == '0) begin
                        data_result    <= w_stage;
                        data_resultRDY <= 1'b1;
                        data_busy      <= 1'b0;
                        r_state        <= S_DONE;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    data_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iterative_shift_unit.sv
// ============================================================================
//  Module   : tb_iterative_shift_unit
//  Brief    : Scoreboard bench for iterative_shift_unit (directed + sweep).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iterative_shift_unit;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int LAT     = 5;

    logic               clock;
    logic               reset;
    logic               ctrl_start;
    logic               ctrl_dir;
    logic [WIDTH-1:0]   data_operand;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [WIDTH-1:0]   data_result;
    logic               data_resultRDY;
    logic               data_busy;

    iterative_shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_dir       (ctrl_dir),
        .data_operand   (data_operand),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .data_busy      (data_busy)
    );

    typedef struct {
        logic [WIDTH-1:0] val;
        int               cyc;
        string            name;
    } exp_t;

    exp_t             sb_q[$];
    int               errors = 0;
    int               checks = 0;
    int               cyc    = 0;
    logic [WIDTH-1:0] hold   = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] a,
                                                   input int amt, input logic dir);
        logic signed [WIDTH-1:0] s;
        s = a;
        return dir ? WIDTH'(s >>> amt) : WIDTH'(a << amt);
    endfunction

    // Monitor: pops one expectation per RDY pulse, checks value and arrival cycle.
    always @(negedge clock) begin
        if (reset) begin
            sb_q.delete();
            hold = '0;
        end else if (data_resultRDY) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: result 0x%08h at cycle %0d", data_result, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_value"}, data_result, e.val);
                check({e.name, "_latency"}, WIDTH'(cyc), WIDTH'(e.cyc));
                hold = e.val;
            end
        end else begin
            check("result_hold", data_result, hold);
        end
    end

    // Drives one request at the current negedge; returns after the accept edge.
    task automatic issue(input logic [WIDTH-1:0] op, input int amt, input logic dir,
                         input logic [WIDTH-1:0] exp, input string name);
        exp_t e;
        data_operand  = op;
        ctrl_shiftamt = SHAMT_W'(amt);
        ctrl_dir      = dir;
        ctrl_start    = 1'b1;
        @(posedge clock);
        #1;
        check({name, "_busy"}, WIDTH'(data_busy), 1);
        e.val = exp; e.cyc = cyc + LAT; e.name = name;
        sb_q.push_back(e);
        ctrl_start = 1'b0;
    endtask

    task automatic do_op(input logic [WIDTH-1:0] op, input int amt, input logic dir,
                         input logic [WIDTH-1:0] exp, input string name);
        int n;
        n = 0;
        @(negedge clock);
        while (data_busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (data_busy) begin
            checks++;
            errors++;
            $display("FAIL %s_wait_idle: busy=1 after 20 cycles, need 0", name);
        end
        issue(op, amt, dir, exp, name);
    endtask

    initial begin
        bit got_rdy;
        reset         = 1'b1;
        ctrl_start    = 1'b0;
        ctrl_dir      = 1'b0;
        data_operand  = '0;
        ctrl_shiftamt = '0;
        #12;
        check("reset_result", data_result, '0);
        check("reset_rdy", WIDTH'(data_resultRDY), 0);
        check("reset_busy", WIDTH'(data_busy), 0);
        @(negedge clock);
        reset = 1'b0;

        do_op(32'h0000_0001, 31, 1'b0, 32'h8000_0000, "sll_1_31");
        do_op(32'h8000_0000,  8, 1'b1, 32'hFF80_0000, "sra_min_8");
        do_op(32'h7FFF_FFF0,  4, 1'b1, 32'h07FF_FFFF, "sra_pos_4");
        do_op(32'hF000_0000,  0, 1'b1, 32'hF000_0000, "sra_amt0");
        do_op(32'h8000_0001,  1, 1'b1, 32'hC000_0000, "sra_neg_1");
        do_op(32'h8000_0000, 15, 1'b1, 32'hFFFF_0000, "sra_neg_15");
        do_op(32'h8765_4321, 16, 1'b1, 32'hFFFF_8765, "sra_neg_16");
        do_op(32'h8000_0000, 31, 1'b1, 32'hFFFF_FFFF, "sra_neg_31");
        do_op(32'h4000_0000, 31, 1'b1, 32'h0000_0000, "sra_pos_31");
        do_op(32'hC000_0001,  1, 1'b0, 32'h8000_0002, "sll_msb_out");
        do_op(32'h1234_5678,  4, 1'b0, 32'h2345_6780, "sll_4");
        do_op(32'hFFFF_FFFF, 16, 1'b0, 32'hFFFF_0000, "sll_16");
        do_op(32'hA5A5_A5A5,  0, 1'b0, 32'hA5A5_A5A5, "sll_amt0");
        do_op(32'h1234_5678,  8, 1'b1, 32'h0012_3456, "sra_pos_8");

        // Start held high with inputs churning while busy; next op lands in RDY cycle.
        do_op(32'h0000_00FF, 8, 1'b0, 32'h0000_FF00, "held_first");
        ctrl_start = 1'b1;
        got_rdy    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                got_rdy = 1'b1;
                break;
            end
            data_operand  = $urandom;
            ctrl_shiftamt = SHAMT_W'($urandom);
            ctrl_dir      = ~ctrl_dir;
        end
        if (!got_rdy) begin
            checks++;
            errors++;
            $display("FAIL held_first_rdy: no RDY within 10 cycles, need 1");
        end
        issue(32'h0000_0F00, 4, 1'b1, 32'h0000_00F0, "held_second");

        // Reset during the third cycle of an op.
        do_op(32'h0000_0003, 2, 1'b0, 32'h0000_000C, "aborted");
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("abort_result", data_result, '0);
        check("abort_rdy", WIDTH'(data_resultRDY), 0);
        check("abort_busy", WIDTH'(data_busy), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        issue(32'h0000_0F0F, 4, 1'b0, 32'h0000_F0F0, "after_reset");

        for (int i = 0; i < 12; i++) begin
            logic [WIDTH-1:0] op;
            int               amt;
            logic             dir;
            op  = $urandom;
            amt = $urandom_range(0, WIDTH - 1);
            dir = 1'($urandom);
            do_op(op, amt, dir, ref_shift(op, amt, dir), "sweep");
        end

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock);
        @(negedge clock);
        check("scoreboard_drained", WIDTH'(sb_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
